// File: rtl/fp_add_rr_sched.sv
// Round-robin scheduler sharing one BF16 adder between NUM_REQ requesters.
// Results travel a tagged pipeline into an in-order response FIFO guarded by issue credits.

module fp_add #(
  parameter int SIG_WIDTH = 7,
  parameter int EXP_WIDTH = 8
) (
  input  logic [SIG_WIDTH+EXP_WIDTH:0] a,
  input  logic [SIG_WIDTH+EXP_WIDTH:0] b,
  input  logic [2:0]                   rnd,
  output logic [SIG_WIDTH+EXP_WIDTH:0] z
);
  localparam int M  = SIG_WIDTH + 1;
  localparam int F  = M + 3;
  localparam int EB = EXP_WIDTH + 2;
  localparam logic [EXP_WIDTH-1:0] EMAX  = '1;
  localparam logic [F-1:0]         ONE_F = 1;
  localparam logic signed [EB-1:0] E_ONE = 1;

  logic                 sl, ss, rup, found;
  logic [EXP_WIDTH-1:0] el, es, d;
  logic [SIG_WIDTH-1:0] fl, fs, frac;
  logic [M-1:0]         ml, ms;
  logic [F-1:0]         ext_s, al_s, lost_mask, nrm;
  logic [F:0]           sum;
  logic signed [EB-1:0] e_n;
  logic [M:0]           rnd_m;
  int                   lz;

  // Subnormal inputs flush to zero; rnd=1 truncates, any other code rounds to nearest-even.
  always_comb begin
    if (a[SIG_WIDTH+EXP_WIDTH-1:0] >= b[SIG_WIDTH+EXP_WIDTH-1:0]) begin
      {sl, el, fl} = a;
      {ss, es, fs} = b;
    end else begin
      {sl, el, fl} = b;
      {ss, es, fs} = a;
    end
    ml        = (el == '0) ? '0 : {1'b1, fl};
    ms        = (es == '0) ? '0 : {1'b1, fs};
    d         = el - es;
    ext_s     = {ms, 3'b000};
    lost_mask = (ONE_F << d) - ONE_F;
    if (int'(d) >= F) al_s = {{(F-1){1'b0}}, |ms};
    else              al_s = (ext_s >> d) | {{(F-1){1'b0}}, |(ext_s & lost_mask)};
    sum   = (sl == ss) ? ({1'b0, ml, 3'b000} + {1'b0, al_s})
                       : ({1'b0, ml, 3'b000} - {1'b0, al_s});
    e_n   = signed'({2'b00, el});
    lz    = 0;
    found = 1'b0;
    if (sum[F]) begin
      nrm = sum[F:1] | {{(F-1){1'b0}}, sum[0]};
      e_n = e_n + E_ONE;
    end else begin
      for (int i = F - 1; i >= 0; i--) begin
        if (!found && sum[i]) begin
          lz    = F - 1 - i;
          found = 1'b1;
        end
      end
      nrm = sum[F-1:0] << lz;
      e_n = e_n - EB'(lz);
    end
    rup   = (rnd != 3'd1) && nrm[2] && (nrm[1] || nrm[0] || nrm[3]);
    rnd_m = {1'b0, nrm[F-1:3]} + {{M{1'b0}}, rup};
    if (rnd_m[M]) e_n = e_n + E_ONE;
    frac  = rnd_m[M] ? '0 : rnd_m[SIG_WIDTH-1:0];
    if (a[SIG_WIDTH+EXP_WIDTH-1 -: EXP_WIDTH] == EMAX)      z = a;
    else if (b[SIG_WIDTH+EXP_WIDTH-1 -: EXP_WIDTH] == EMAX) z = b;
    else if (sum == '0)                                     z = '0;
    else if (e_n >= signed'({2'b00, EMAX}))                 z = {sl, EMAX, {SIG_WIDTH{1'b0}}};
    else if (e_n < E_ONE)                                   z = {sl, {(SIG_WIDTH+EXP_WIDTH){1'b0}}};
    else                                                    z = {sl, e_n[EXP_WIDTH-1:0], frac};
  end
endmodule

module fp_add_rr_sched #(
  parameter int NUM_REQ     = 4,
  parameter int SIG_WIDTH   = 7,
  parameter int EXP_WIDTH   = 8,
  parameter int PIPE_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  localparam int W   = SIG_WIDTH + EXP_WIDTH + 1,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [W-1:0]         rsp_z,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy,
  output logic [15:0]          issue_cnt
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDW-1:0] ID_ONE = 1;
  localparam logic [CW-1:0]  C_ONE  = 1;
  localparam logic [AW:0]    P_ONE  = 1;

  logic [IDW-1:0] rr_ptr, grant, idx;
  logic           grant_vld, can_issue, accept, pop, wr_en;
  logic [CW-1:0]  credit;
  logic [W-1:0]   a_sel, b_sel, sum_z;
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           vld_p [PIPE_STAGES];
  logic [W-1:0]   z_p   [PIPE_STAGES];
  logic [IDW-1:0] id_p  [PIPE_STAGES];
  logic [W-1:0]   mem_z  [2**AW];
  logic [IDW-1:0] mem_id [2**AW];

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == IDW'(NUM_REQ - 1)) ? '0 : idx + ID_ONE;
      if (!grant_vld && req_valid[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  assign can_issue = credit < CW'(FIFO_DEPTH);

  always_comb begin
    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IDW'(i)) begin
        req_ready[i] = grant_vld && can_issue && !rst;
        a_sel        = req_a[i*W +: W];
        b_sel        = req_b[i*W +: W];
      end
    end
  end

  assign accept    = |(req_valid & req_ready);
  assign pop       = rsp_valid && rsp_ready;
  assign wr_en     = vld_p[PIPE_STAGES-1];
  assign rsp_valid = wr_ptr != rd_ptr;
  assign rsp_z     = rsp_valid ? mem_z[rd_ptr[AW-1:0]] : '0;
  assign rsp_id    = rsp_valid ? mem_id[rd_ptr[AW-1:0]] : '0;
  assign busy      = credit != '0;

  fp_add #(.SIG_WIDTH(SIG_WIDTH), .EXP_WIDTH(EXP_WIDTH)) u_fp_add (
    .a(a_sel), .b(b_sel), .rnd(3'd0), .z(sum_z)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= IDW'(NUM_REQ - 1);
      issue_cnt <= '0;
      credit    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) vld_p[i] <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr    <= grant;
        issue_cnt <= issue_cnt + 16'd1;
      end
      if (accept && !pop)      credit <= credit + C_ONE;
      else if (!accept && pop) credit <= credit - C_ONE;
      // stage boundary: adder output -> tagged pipeline -> FIFO write
      vld_p[0] <= accept;
      for (int i = 1; i < PIPE_STAGES; i++) vld_p[i] <= vld_p[i-1];
      if (wr_en) wr_ptr <= wr_ptr + P_ONE;
      if (pop)   rd_ptr <= rd_ptr + P_ONE;
    end
  end

  always_ff @(posedge clk) begin
    z_p[0]  <= sum_z;
    id_p[0] <= grant;
    for (int i = 1; i < PIPE_STAGES; i++) begin
      z_p[i]  <= z_p[i-1];
      id_p[i] <= id_p[i-1];
    end
    if (wr_en) begin
      mem_z[wr_ptr[AW-1:0]]  <= z_p[PIPE_STAGES-1];
      mem_id[wr_ptr[AW-1:0]] <= id_p[PIPE_STAGES-1];
    end
  end
endmodule

// File: tb/tb_fp_add_rr_sched.sv
// Scoreboard bench for fp_add_rr_sched: accepts push expected {id, z}, a monitor pops on each response.
// Operand/sum pairs are hand-computed BF16 round-to-nearest-even results.

module tb_fp_add_rr_sched;
  typedef struct packed { logic [15:0] a, b, z; } vec_t;
  typedef struct packed { logic [1:0] id; logic [15:0] z; } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, busy;
  logic [15:0] rsp_z, issue_cnt;
  logic [1:0]  rsp_id;

  vec_t pool [12];
  exp_t sb [$];
  exp_t e;
  int n_vec = 0, n_bad = 0;
  int cred = 0, last_grant = 3, n_acc = 0, nv = 0, n_sim = 0;
  int rem [4];
  int cur [4];
  logic [15:0] hz;
  logic [1:0]  hid;
  int a0;

  fp_add_rr_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_id(rsp_id), .busy(busy), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic load(input int g, input int n);
    rem[g] = n;
    cur[g] = nv;
    req_a[g*16 +: 16] = pool[nv].a;
    req_b[g*16 +: 16] = pool[nv].b;
    req_valid[g] = 1'b1;
    nv = (nv + 1) % 12;
  endtask

  task automatic cycle();
    logic [3:0] acc;
    logic       popv;
    int         g;
    @(negedge clk);
    acc  = req_valid & req_ready;
    popv = rsp_valid & rsp_ready;
    g    = -1;
    chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    chk("ready_credit", 32'(req_ready != 4'b0), 32'(req_valid != 4'b0 && cred < 4));
    chk("busy_credit", 32'(busy), 32'(cred != 0));
    for (int i = 0; i < 4; i++) if (acc[i]) g = i;
    if (g >= 0) begin
      if (req_valid == 4'hF) chk("rr_order", 32'(g), 32'((last_grant + 1) % 4));
      if (popv && cred == 3) n_sim++;
      sb.push_back('{id: 2'(g), z: pool[cur[g]].z});
      last_grant = g;
      n_acc++;
      rem[g]--;
    end
    cred = cred + ((g >= 0) ? 1 : 0) - (popv ? 1 : 0);
    @(posedge clk);
    #1;
    if (g >= 0) begin
      if (rem[g] > 0) load(g, rem[g]);
      else req_valid[g] = 1'b0;
    end
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((rem[0] + rem[1] + rem[2] + rem[3] > 0 || sb.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_budget", 32'(n < budget), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL rsp_unexpected: got id %0d z %h expected no response", rsp_id, rsp_z);
      end else begin
        e = sb.pop_front();
        chk("rsp_z", 32'(rsp_z), 32'(e.z));
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pool[0]  = '{16'h3F80, 16'h4000, 16'h4040}; // 1 + 2 = 3
    pool[1]  = '{16'h4040, 16'h4080, 16'h40E0}; // 3 + 4 = 7
    pool[2]  = '{16'h4120, 16'hC0A0, 16'h40A0}; // 10 - 5 = 5
    pool[3]  = '{16'h3F81, 16'h3B80, 16'h3F82}; // tie, odd lsb rounds up
    pool[4]  = '{16'h3F80, 16'h3B80, 16'h3F80}; // tie, even lsb stays
    pool[5]  = '{16'h4380, 16'h3F80, 16'h4380}; // 256 + 1 ties to even
    pool[6]  = '{16'h4380, 16'h3FC0, 16'h4381}; // 256 + 1.5 rounds up
    pool[7]  = '{16'h4000, 16'hBF81, 16'h3F7E}; // 2 - 1.0078125
    pool[8]  = '{16'h3F80, 16'hBF81, 16'hBC00}; // 1 - 1.0078125 = -2^-7
    pool[9]  = '{16'h3F80, 16'hBF80, 16'h0000}; // exact cancellation
    pool[10] = '{16'hC000, 16'h3F80, 16'hBF80}; // -2 + 1 = -1
    pool[11] = '{16'h3F80, 16'h3F80, 16'h4000}; // 1 + 1 = 2
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      cur[i] = 0;
    end
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_z", 32'(rsp_z), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // single operation, latency and busy profile
    rsp_ready = 1'b1;
    load(0, 1);
    #1;
    chk("p1_ready", 32'(req_ready), 32'h1);
    cycle();
    chk("p1_busy", 32'(busy), 32'd1);
    chk("p1_cnt", 32'(issue_cnt), 32'd1);
    chk("p1_valid_k0", 32'(rsp_valid), 32'd0);
    cycle();
    chk("p1_valid_k1", 32'(rsp_valid), 32'd0);
    cycle();
    chk("p1_valid_k2", 32'(rsp_valid), 32'd1);
    chk("p1_z", 32'(rsp_z), 32'h4040);
    chk("p1_id", 32'(rsp_id), 32'd0);
    cycle();
    chk("p1_idle_busy", 32'(busy), 32'd0);
    chk("p1_idle_valid", 32'(rsp_valid), 32'd0);

    // round robin with all requesters valid
    for (int g = 0; g < 4; g++) load(g, 5);
    drain(100);
    chk("p2_cnt", 32'(issue_cnt), 32'(n_acc));

    // backpressure fills the credit window
    rsp_ready = 1'b0;
    for (int g = 0; g < 4; g++) load(g, 3);
    a0 = n_acc;
    repeat (6) cycle();
    chk("p3_accepts", 32'(n_acc - a0), 32'd4);
    chk("p3_ready_zero", 32'(req_ready), 32'd0);
    chk("p3_busy", 32'(busy), 32'd1);
    chk("p3_valid", 32'(rsp_valid), 32'd1);
    hz  = rsp_z;
    hid = rsp_id;
    repeat (2) cycle();
    chk("p3_z_stable", 32'(rsp_z), 32'(hz));
    chk("p3_id_stable", 32'(rsp_id), 32'(hid));
    rsp_ready = 1'b1;
    #1;
    chk("p3_no_bypass", 32'(req_ready), 32'd0);
    cycle();
    chk("p3_ready_after_pop", 32'(req_ready != 4'b0), 32'd1);
    drain(100);

    // intermittent consumer: accept+pop at credit 3, FIFO pointer wrap over 20 ops
    for (int g = 0; g < 4; g++) load(g, 5);
    for (int c = 0; c < 200 && (rem[0] + rem[1] + rem[2] + rem[3] > 0 || sb.size() > 0); c++) begin
      rsp_ready = (c % 3 != 2);
      cycle();
    end
    rsp_ready = 1'b1;
    drain(50);
    chk("p4_accept_pop_at_3", 32'(n_sim > 0), 32'd1);
    chk("p4_cnt", 32'(issue_cnt), 32'(n_acc));

    // asynchronous reset with work in flight
    rsp_ready = 1'b0;
    load(0, 1);
    load(1, 1);
    load(2, 1);
    repeat (3) cycle();
    chk("p6_pending", 32'(rsp_valid), 32'd1);
    for (int g = 0; g < 4; g++) load(g, 1);
    #2 rst = 1'b1;
    #1;
    chk("p6_rst_valid", 32'(rsp_valid), 32'd0);
    chk("p6_rst_ready", 32'(req_ready), 32'd0);
    chk("p6_rst_busy", 32'(busy), 32'd0);
    chk("p6_rst_cnt", 32'(issue_cnt), 32'd0);
    sb.delete();
    cred = 0;
    last_grant = 3;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("p6_cnt_after", 32'(issue_cnt), 32'd0);
    chk("p6_valid_after", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b1;
    last_grant = 3;
    cycle();
    chk("p6_first_grant", 32'(last_grant), 32'd0);
    drain(50);
    chk("p6_cnt_end", 32'(issue_cnt), 32'd4);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
